regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised successor to the pipeline's register bank. Provides NRD combinational read ports, NWR synchronous write-back ports and optional write-through bypass. Adds a per-register busy scoreboard so decode can stall on RAW and WAW hazards against multi-cycle producers. Sits in the decode stage, between IF/ID and ID/EX; write-back ports are driven from the WB stage.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; power of 2, at least 2
NRD, 2, number of read ports
NWR, 1, number of write-back ports
AW (localparam), $clog2(NREGS), register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rd_en  in  NRD  read port i is in use this cycle
rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  read data; port i at [i*XLEN +: XLEN]
iss_valid  in  1  decode wants to issue an instruction that writes iss_rd
iss_rd  in  AW  destination register of the issuing instruction
iss_fire  out  1  issue accepted this cycle; equals iss_valid & ~stall
stall  out  1  hazard; decode must hold IF/ID and insert a bubble into ID/EX
wb_en  in  NWR  write-back port j is valid
wb_addr  in  NWR*AW  write-back addresses
wb_data  in  NWR*XLEN  write-back data
busy_vec  out  NREGS  scoreboard state, for debug and verification

Behaviour:
- Reset: clk and rst are fixed as one clock with a synchronous, active-high reset. On the first rising clk edge with rst=1:
  - all registers are set to 0;
  - busy_vec is set to 0.
  - Combinational outputs then follow: stall=0 and iss_fire=iss_valid.
  - A reset asserted mid-operation discards all pending busy bits, and any write-back presented in that cycle is dropped.
- Register 0 is hardwired to zero:
  - reads of it return 0;
  - writes to it are ignored;
  - busy_vec[0] is always 0.
- Reads are combinational with zero latency. rd_data[i] equals the register contents, except when bypassed (see Optional Feature).
- Writes take effect at the clk edge.
  - If several wb ports target the same register in one cycle, the highest-index port j wins.
- stall is the OR of two hazard terms:
  - RAW: for some read port i, rd_en[i] is set and rd_addr[i] is busy and not cleared this cycle;
  - WAW: iss_valid is set and iss_rd is busy and not cleared this cycle.
  - "Cleared this cycle" applies only when the bypass is enabled.
- Scoreboard update at each clk edge, with rst=0:
  - A register's busy bit clears when any wb_en[j] is set with wb_addr[j] equal to that register.
  - It sets when iss_fire is set and iss_rd equals that register, and the register is non-zero.
  - If set and clear happen for the same register in the same cycle, set wins (the newer producer).
- wb to a register that is not busy is legal: data is written and busy stays 0.
- At most one outstanding producer per register is guaranteed by the WAW stall, so single busy bits suffice.
- iss_valid with iss_rd=0 never stalls on WAW and never sets busy.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding: if wb_en[j] is set and wb_addr[j]==rd_addr[i] (non-zero), rd_data[i] returns wb_data[j], highest j winning.
  - A register being written back this cycle counts as not busy for the RAW and WAW terms of stall.
- Undefined:
  - rd_data always returns the stored array value, so the new value is visible the cycle after write-back.
  - busy registers stall until the edge after their write-back, which costs one extra stall cycle per dependency.

Decomposition:
- Shared package regfile_pkg holds:
  - default XLEN/NREGS constants;
  - typedef reg_addr_t (AW bits);
  - typedef xword_t (XLEN bits);
  - the ZERO_REG constant.
- One natural sub-module, rf_scoreboard: the busy-bit array with set/clear/priority logic, producing busy_vec and the per-address hazard lookup.
- The storage array, read muxes and bypass stay in the top module.

Test Plan:
- Reset then read: after rst, read r5 and r31 -> rd_data=0 and busy_vec=0.
- Write and read back: wb r3=0xDEADBEEF, read r3 next cycle -> 0xDEADBEEF. Write r0=0x1234 -> r0 still reads 0.
- RAW stall: issue r7, then read r7 with rd_en=1 -> stall=1 each cycle until the wb to r7.
  - With REGFILE_BYPASS_EN: stall=0 in the wb cycle, and rd_data equals wb_data=0x55.
  - Without it: stall=0 from the next cycle, and the read returns 0x55.
- WAW and same-cycle set/clear: issue r9, then issue r9 again -> stall=1 and iss_fire=0. Issue r4 in the same cycle as the wb to r4 -> busy_vec[4] stays 1.
- Multi-port conflict (NWR=2): wb0 r6=0x11 and wb1 r6=0x22 in the same cycle -> r6 reads 0x22 and busy_vec[6] is cleared.
- Mid-operation reset: busy r2/r8, assert rst for one cycle together with a wb to r2 -> busy_vec=0, r2=0, stall=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with busy scoreboard.
package regfile_pkg;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_if.sv
// Decode/write-back bus of the register file; master is the pipeline side, slave is the register file.
interface regfile_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_fire;
  logic                stall;
  logic [NWR-1:0]      wb_en;
  logic [NWR*AW-1:0]   wb_addr;
  logic [NWR*XLEN-1:0] wb_data;
  logic [NREGS-1:0]    busy_vec;

  modport master (
    output rd_en, rd_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data,
    input  rd_data, iss_fire, stall, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data,
    output rd_data, iss_fire, stall, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard_sb.sv
// Per-register busy bits with set/clear priority and RAW/WAW hazard lookup.
// With REGFILE_BYPASS_EN a register written back this cycle is treated as not busy.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              iss_fire,
  input  logic [NWR-1:0]    wb_en,
  input  logic [NWR*AW-1:0] wb_addr,
  output logic [NREGS-1:0]  busy_vec,
  output logic              raw_hazard,
  output logic              waw_hazard
);
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] busy_eff;

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wb_en[j]) clr_vec[wb_addr[j*AW +: AW]] = 1'b1;
    end
    if (iss_fire && (iss_rd != AW'(ZERO_REG))) set_vec[iss_rd] = 1'b1;
  end

`ifdef REGFILE_BYPASS_EN
  assign busy_eff = busy_q & ~clr_vec;
`else
  assign busy_eff = busy_q;
`endif

  always_comb begin
    raw_hazard = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (rd_en[i] && busy_eff[rd_addr[i*AW +: AW]]) raw_hazard = 1'b1;
    end
    waw_hazard = iss_valid && busy_eff[iss_rd];
  end

  // Set is applied after clear so a new producer overrides a retiring one.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= (busy_q & ~clr_vec) | set_vec;
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Register bank with NRD combinational reads, NWR write-back ports and a busy scoreboard.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic            raw_hazard;
  logic            waw_hazard;
  logic [AW-1:0]   rd_a;

  rf_scoreboard #(
    .NREGS(NREGS),
    .NRD  (NRD),
    .NWR  (NWR),
    .AW   (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (bus.rd_en),
    .rd_addr   (bus.rd_addr),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .iss_fire  (bus.iss_fire),
    .wb_en     (bus.wb_en),
    .wb_addr   (bus.wb_addr),
    .busy_vec  (bus.busy_vec),
    .raw_hazard(raw_hazard),
    .waw_hazard(waw_hazard)
  );

  assign bus.stall    = raw_hazard | waw_hazard;
  assign bus.iss_fire = bus.iss_valid & ~bus.stall;

  // Ascending port order lets the last non-blocking update, the highest port, win.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NREGS; k++) regs[k] <= '0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (bus.wb_en[j] && (bus.wb_addr[j*AW +: AW] != AW'(ZERO_REG)))
          regs[bus.wb_addr[j*AW +: AW]] <= bus.wb_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    rd_a        = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_a = bus.rd_addr[i*AW +: AW];
      if (rd_a != AW'(ZERO_REG)) begin
        bus.rd_data[i*XLEN +: XLEN] = regs[rd_a];
`ifdef REGFILE_BYPASS_EN
        for (int unsigned j = 0; j < NWR; j++) begin
          if (bus.wb_en[j] && (bus.wb_addr[j*AW +: AW] == rd_a))
            bus.rd_data[i*XLEN +: XLEN] = bus.wb_data[j*XLEN +: XLEN];
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scenario bench for regfile_scoreboard (NRD=2, NWR=2); expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     checks = 0;
  int     errors = 0;
  xword_t exp_q[$];
  xword_t e;

  regfile_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic idle();
    bus.rd_en     = '0;
    bus.rd_addr   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.wb_en     = '0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; step(); rst = 1'b0;
    bus.rd_en = 2'b11; bus.rd_addr = {5'd31, 5'd5};
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if (bus.rd_data[31:0] !== e) begin errors++; $display("FAIL reset_rd_r5 act=%h exp=%h", bus.rd_data[31:0], e); end
    e = exp_q.pop_front(); checks++; if (bus.rd_data[63:32] !== e) begin errors++; $display("FAIL reset_rd_r31 act=%h exp=%h", bus.rd_data[63:32], e); end
    e = exp_q.pop_front(); checks++; if (bus.busy_vec !== e) begin errors++; $display("FAIL reset_busy act=%h exp=%h", bus.busy_vec, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.stall} !== e) begin errors++; $display("FAIL reset_stall act=%b exp=%h", bus.stall, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.iss_fire} !== e) begin errors++; $display("FAIL reset_iss_fire act=%b exp=%h", bus.iss_fire, e); end
    bus.iss_valid = 1'b0;
  endtask

  task automatic test_write_read();
    step(); idle();
    bus.wb_en = 2'b01; bus.wb_addr[4:0] = 5'd3; bus.wb_data[31:0] = 32'hDEADBEEF;
    step(); idle();
    bus.rd_en = 2'b01; bus.rd_addr[4:0] = 5'd3;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if (bus.rd_data[31:0] !== e) begin errors++; $display("FAIL wr_rd_r3 act=%h exp=%h", bus.rd_data[31:0], e); end
    e = exp_q.pop_front(); checks++; if (bus.busy_vec !== e) begin errors++; $display("FAIL wr_nonbusy_busy act=%h exp=%h", bus.busy_vec, e); end
    step(); idle();
    bus.wb_en = 2'b01; bus.wb_addr[4:0] = 5'd0; bus.wb_data[31:0] = 32'h1234;
    step(); idle();
    bus.rd_en = 2'b01; bus.rd_addr[4:0] = 5'd0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if (bus.rd_data[31:0] !== e) begin errors++; $display("FAIL wr_r0_ignored act=%h exp=%h", bus.rd_data[31:0], e); end
  endtask

  task automatic test_raw();
    step(); idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    step(); idle();
    bus.rd_en = 2'b01; bus.rd_addr[4:0] = 5'd7;
    exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.stall} !== e) begin errors++; $display("FAIL raw_stall_c1 act=%b exp=%h", bus.stall, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.busy_vec[7]} !== e) begin errors++; $display("FAIL raw_busy7 act=%b exp=%h", bus.busy_vec[7], e); end
    step();
    exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.stall} !== e) begin errors++; $display("FAIL raw_stall_c2 act=%b exp=%h", bus.stall, e); end
    step();
    bus.wb_en = 2'b01; bus.wb_addr[4:0] = 5'd7; bus.wb_data[31:0] = 32'h55;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h0); exp_q.push_back(32'h55);
`else
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
`endif
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.stall} !== e) begin errors++; $display("FAIL raw_stall_wb act=%b exp=%h", bus.stall, e); end
    e = exp_q.pop_front(); checks++; if (bus.rd_data[31:0] !== e) begin errors++; $display("FAIL raw_rd_wb act=%h exp=%h", bus.rd_data[31:0], e); end
    step();
    bus.wb_en = '0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h55); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.stall} !== e) begin errors++; $display("FAIL raw_stall_after act=%b exp=%h", bus.stall, e); end
    e = exp_q.pop_front(); checks++; if (bus.rd_data[31:0] !== e) begin errors++; $display("FAIL raw_rd_after act=%h exp=%h", bus.rd_data[31:0], e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.busy_vec[7]} !== e) begin errors++; $display("FAIL raw_busy7_clr act=%b exp=%h", bus.busy_vec[7], e); end
  endtask

  task automatic test_waw();
    step(); idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    step();
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.stall} !== e) begin errors++; $display("FAIL waw_stall act=%b exp=%h", bus.stall, e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.iss_fire} !== e) begin errors++; $display("FAIL waw_iss_fire act=%b exp=%h", bus.iss_fire, e); end
    step(); idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    bus.wb_en = 2'b01; bus.wb_addr[4:0] = 5'd4; bus.wb_data[31:0] = 32'h44;
    exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.iss_fire} !== e) begin errors++; $display("FAIL setclr_fire act=%b exp=%h", bus.iss_fire, e); end
    step(); idle();
    exp_q.push_back(32'h0000_0210);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if (bus.busy_vec !== e) begin errors++; $display("FAIL setclr_busy act=%h exp=%h", bus.busy_vec, e); end
    bus.wb_en = 2'b11; bus.wb_addr = {5'd4, 5'd9};
    step(); idle();
    exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if (bus.busy_vec !== e) begin errors++; $display("FAIL waw_drain_busy act=%h exp=%h", bus.busy_vec, e); end
  endtask

  task automatic test_multi_port();
    step(); idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd6;
    step(); idle();
    bus.wb_en = 2'b11; bus.wb_addr = {5'd6, 5'd6}; bus.wb_data = {32'h22, 32'h11};
    bus.rd_en = 2'b10; bus.rd_addr[9:5] = 5'd6;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h22);
`else
    exp_q.push_back(32'h0);
`endif
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if (bus.rd_data[63:32] !== e) begin errors++; $display("FAIL mp_rd_wbcycle act=%h exp=%h", bus.rd_data[63:32], e); end
    step(); idle();
    bus.rd_en = 2'b10; bus.rd_addr[9:5] = 5'd6;
    exp_q.push_back(32'h22); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if (bus.rd_data[63:32] !== e) begin errors++; $display("FAIL mp_rd_r6 act=%h exp=%h", bus.rd_data[63:32], e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.busy_vec[6]} !== e) begin errors++; $display("FAIL mp_busy6 act=%b exp=%h", bus.busy_vec[6], e); end
  endtask

  task automatic test_mid_reset();
    step(); idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd2;
    step();
    bus.iss_rd = 5'd8;
    step(); idle();
    exp_q.push_back(32'h0000_0104);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if (bus.busy_vec !== e) begin errors++; $display("FAIL mr_busy_pre act=%h exp=%h", bus.busy_vec, e); end
    rst = 1'b1;
    bus.wb_en = 2'b01; bus.wb_addr[4:0] = 5'd2; bus.wb_data[31:0] = 32'hAA;
    step(); rst = 1'b0; idle();
    bus.rd_en = 2'b11; bus.rd_addr = {5'd3, 5'd2};
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++; if (bus.busy_vec !== e) begin errors++; $display("FAIL mr_busy act=%h exp=%h", bus.busy_vec, e); end
    e = exp_q.pop_front(); checks++; if (bus.rd_data[31:0] !== e) begin errors++; $display("FAIL mr_rd_r2 act=%h exp=%h", bus.rd_data[31:0], e); end
    e = exp_q.pop_front(); checks++; if (bus.rd_data[63:32] !== e) begin errors++; $display("FAIL mr_rd_r3 act=%h exp=%h", bus.rd_data[63:32], e); end
    e = exp_q.pop_front(); checks++; if ({31'b0, bus.stall} !== e) begin errors++; $display("FAIL mr_stall act=%b exp=%h", bus.stall, e); end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_raw();
    test_waw();
    test_multi_port();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
